mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous data/instruction RAM between the CPU fetch port and its load/store port.

---
 rtl/rv_mem_pkg.sv | 29 ++
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/arb_streak_counter.sv | 31 +++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_mem_pkg.sv
// Shared types for the CPU memory-port arbiter. The arbiter, its interface and
// its streak counter all import this package.
package rv_mem_pkg;

    // Tracks which port received the access granted in the previous cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } mem_owner_e;

    // Byte-enable width of the 32-bit data path.
    localparam int BE_W = 4;

    // Writes the enabled byte lanes of new_word over old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0]     old_word,
                                                input logic [31:0]     new_word,
                                                input logic [BE_W-1:0] be);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the RAM port that meet at
// the arbiter. The slave view belongs to the arbiter; the master view belongs
// to the CPU and RAM around it.
interface mem_port_arbiter_if
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);

    // Fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // Load/store port
    logic              d_req;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // Single-port RAM
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_we, mem_be, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/arb_streak_counter.sv
// Saturating counter of consecutive data grants taken while a fetch waits.
// Clear has priority over increment.
module arb_streak_counter #(
    parameter int MAX   = 4,
    parameter int WIDTH = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;

    // Count up to MAX and stick there; clear as soon as fetch is served or idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_CNT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the CPU fetch port and its
// load/store port. The data port wins ties unless it has already taken
// MAX_DSTREAK grants in a row while fetch was waiting. Read data returns one
// cycle after the grant to whichever port owned that grant.
module mem_port_arbiter
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_DSTREAK);

    logic [STREAK_W-1:0] w_streak;
    logic                w_at_limit;
    logic                w_d_gnt;
    logic                w_if_gnt;
    logic                w_streak_inc;
    logic                w_streak_clr;

    mem_owner_e          r_owner;
    logic                r_d_store;
    logic [ADDR_W-1:0]   r_last_addr;
    logic [DATA_W-1:0]   r_if_hold;
    logic [DATA_W-1:0]   r_d_hold;

    logic                w_if_rvalid;
    logic                w_d_rvalid;
    logic [DATA_W-1:0]   w_d_ret;

    // ------------------------------------------------------------------
    // Grant decision: data first, unless fetch has waited through a full streak.
    // ------------------------------------------------------------------
    assign w_at_limit = (w_streak == STREAK_LIMIT);
    assign w_d_gnt    = bus.d_req & ~(bus.if_req & w_at_limit);
    assign w_if_gnt   = bus.if_req & ~w_d_gnt;

    // The streak only grows while fetch is actually being held off.
    assign w_streak_inc = w_d_gnt & bus.if_req;
    assign w_streak_clr = w_if_gnt | ~bus.if_req;

    arb_streak_counter #(
        .MAX   (MAX_DSTREAK),
        .WIDTH (STREAK_W)
    ) u_streak (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_streak_inc),
        .i_clr   (w_streak_clr),
        .o_count (w_streak)
    );

    // ------------------------------------------------------------------
    // RAM request mux. The address parks on its last value between grants so
    // the RAM address bus does not toggle when idle.
    // ------------------------------------------------------------------
    assign bus.if_gnt    = w_if_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.mem_addr  = w_d_gnt  ? bus.d_addr :
                           w_if_gnt ? bus.if_addr : r_last_addr;
    assign bus.mem_we    = w_d_gnt & bus.d_we;
    assign bus.mem_be    = w_d_gnt ? bus.d_be : '0;
    assign bus.mem_wdata = w_d_gnt ? bus.d_wdata : '0;

    // Remember the address of the most recent grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_addr <= '0;
        end else if (w_d_gnt || w_if_gnt) begin
            r_last_addr <= bus.mem_addr;
        end
    end

    // Record who owns the RAM response arriving next cycle; reset drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner   <= OWN_NONE;
            r_d_store <= 1'b0;
        end else begin
            if (w_d_gnt) begin
                r_owner <= OWN_D;
            end else if (w_if_gnt) begin
                r_owner <= OWN_IF;
            end else begin
                r_owner <= OWN_NONE;
            end
            r_d_store <= w_d_gnt & bus.d_we;
        end
    end

    // ------------------------------------------------------------------
    // Response routing. RAM data is passed straight through in the return
    // cycle; afterwards each port keeps showing its last returned word.
    // ------------------------------------------------------------------
    assign w_if_rvalid = (r_owner == OWN_IF);
    assign w_d_rvalid  = (r_owner == OWN_D);
    assign w_d_ret     = r_d_store ? '0 : bus.mem_rdata;

    // Capture each returned word so rdata holds steady while rvalid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_hold <= '0;
            r_d_hold  <= '0;
        end else begin
            if (w_if_rvalid) begin
                r_if_hold <= bus.mem_rdata;
            end
            if (w_d_rvalid) begin
                r_d_hold <= w_d_ret;
            end
        end
    end

    assign bus.if_rvalid = w_if_rvalid;
    assign bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : r_if_hold;
    assign bus.d_rvalid  = w_d_rvalid;
    assign bus.d_rdata   = w_d_rvalid ? w_d_ret : r_d_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// protocol-respecting random traffic, all compared against a transaction-level
// reference model kept in this file. A word-addressed RAM with 1-cycle read
// latency is modelled here and attached to the arbiter's RAM port.
module tb_mem_port_arbiter;
    import rv_mem_pkg::*;

    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 32;
    localparam int MAX_DSTREAK = 4;
    localparam int NWORDS      = 32;

    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MAX_DSTREAK (MAX_DSTREAK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM attached to the arbiter ----------------
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (bus_if.mem_we) begin
            ram[bus_if.mem_addr] <= merge_bytes(ram[bus_if.mem_addr], bus_if.mem_wdata, bus_if.mem_be);
        end
        bus_if.mem_rdata <= ram[bus_if.mem_addr];
    end

    // ---------------- reference model state ----------------
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
    int                m_streak;      // data grants taken since fetch began waiting
    bit                m_pend_if;     // a fetch response is due this cycle
    bit                m_pend_d;      // a data response is due this cycle
    logic [DATA_W-1:0] m_if_exp;
    logic [DATA_W-1:0] m_d_exp;
    logic [DATA_W-1:0] m_if_hold;
    logic [DATA_W-1:0] m_d_hold;
    logic [ADDR_W-1:0] m_last_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_streak    = 0;
        m_pend_if   = 1'b0;
        m_pend_d    = 1'b0;
        m_if_exp    = '0;
        m_d_exp     = '0;
        m_if_hold   = '0;
        m_d_hold    = '0;
        m_last_addr = '0;
    endtask

    // One bus cycle: present requests, check grants/RAM port/responses, let
    // the clock edge happen, advance the model. Starts and ends at a negedge.
    task automatic step(input bit ifr, input logic [ADDR_W-1:0] ifa,
                        input bit dr, input bit dwe, input logic [3:0] dbe,
                        input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dwd,
                        output bit gi, output bit gd);
        bit egd;
        bit egi;
        bus_if.if_req  = ifr;
        bus_if.if_addr = ifa;
        bus_if.d_req   = dr;
        bus_if.d_we    = dwe;
        bus_if.d_be    = dbe;
        bus_if.d_addr  = da;
        bus_if.d_wdata = dwd;
        #1;
        egd = dr && !(ifr && (m_streak >= MAX_DSTREAK));
        egi = ifr && !egd;
        gi  = bus_if.if_gnt;
        gd  = bus_if.d_gnt;
        chk("d_gnt", 64'(bus_if.d_gnt), 64'(egd));
        chk("if_gnt", 64'(bus_if.if_gnt), 64'(egi));
        chk("mem_we", 64'(bus_if.mem_we), 64'(egd && dwe));
        if (egd) begin
            chk("mem_addr_d", 64'(bus_if.mem_addr), 64'(da));
            chk("mem_be_d", 64'(bus_if.mem_be), 64'(dbe));
            if (dwe) chk("mem_wdata", 64'(bus_if.mem_wdata), 64'(dwd));
        end else if (egi) begin
            chk("mem_addr_if", 64'(bus_if.mem_addr), 64'(ifa));
        end else begin
            chk("mem_addr_hold", 64'(bus_if.mem_addr), 64'(m_last_addr));
            chk("mem_be_idle", 64'(bus_if.mem_be), 64'(0));
        end
        chk("if_rvalid", 64'(bus_if.if_rvalid), 64'(m_pend_if));
        chk("d_rvalid", 64'(bus_if.d_rvalid), 64'(m_pend_d));
        chk("if_rdata", 64'(bus_if.if_rdata), 64'(m_pend_if ? m_if_exp : m_if_hold));
        chk("d_rdata", 64'(bus_if.d_rdata), 64'(m_pend_d ? m_d_exp : m_d_hold));
        $display("[TB] t=%0t if_req=%0b d_req=%0b we=%0b gi=%0b gd=%0b if_rv=%0b d_rv=%0b",
                 $time, ifr, dr, dwe, gi, gd, bus_if.if_rvalid, bus_if.d_rvalid);
        @(posedge clk);
        if (m_pend_if) m_if_hold = m_if_exp;
        if (m_pend_d)  m_d_hold  = m_d_exp;
        m_pend_if = egi;
        m_pend_d  = egd;
        if (egi) begin
            m_if_exp    = shadow[ifa];
            m_last_addr = ifa;
        end
        if (egd) begin
            m_d_exp     = dwe ? '0 : shadow[da];
            m_last_addr = da;
            if (dwe) shadow[da] = merge_bytes(shadow[da], dwd, dbe);
        end
        if (egi || !ifr) m_streak = 0;
        else if (egd && ifr && m_streak < MAX_DSTREAK) m_streak = m_streak + 1;
        @(negedge clk);
    endtask

    bit                g_i, g_d;
    logic [9:0]        gseq;
    bit                r_ifr, r_dr, r_dwe;
    logic [ADDR_W-1:0] r_ifa, r_da;
    logic [3:0]        r_dbe;
    logic [DATA_W-1:0] r_dwd;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        pre_we  = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        bus_if.if_req = 1'b0; bus_if.if_addr = '0;
        bus_if.d_req = 1'b0; bus_if.d_we = 1'b0; bus_if.d_be = '0;
        bus_if.d_addr = '0; bus_if.d_wdata = '0;
        model_reset();

        // Reset state and RAM preload (word 1 holds the instruction for step 1).
        @(negedge clk);
        chk("rst_if_rvalid", 64'(bus_if.if_rvalid), 64'(0));
        chk("rst_d_rvalid", 64'(bus_if.d_rvalid), 64'(0));
        chk("rst_if_rdata", 64'(bus_if.if_rdata), 64'(0));
        chk("rst_d_rdata", 64'(bus_if.d_rdata), 64'(0));
        chk("rst_gnt", 64'({bus_if.if_gnt, bus_if.d_gnt}), 64'(0));
        for (int a = 0; a < NWORDS; a++) begin
            pre_we   = 1'b1;
            pre_addr = ADDR_W'(a);
            pre_data = (a == 1) ? 32'h0226_8193 : $urandom;
            shadow[a] = pre_data;
            @(negedge clk);
        end
        pre_we = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);

        // 1: fetch alone, byte address 0x004 = word 1.
        step(1, 10'd1, 0, 0, 4'h0, 10'd0, 32'h0, g_i, g_d);
        chk("t1_if_gnt", 64'(g_i), 64'(1));
        step(0, 10'd0, 0, 0, 4'h0, 10'd0, 32'h0, g_i, g_d);
        chk("t1_if_rdata", 64'(bus_if.if_rdata), 64'h0226_8193);

        // 2: simultaneous requests, load from byte 0x010 = word 4 wins; fetch next.
        step(1, 10'd2, 1, 0, 4'h0, 10'd4, 32'h0, g_i, g_d);
        chk("t2_dgnt_first", 64'({g_i, g_d}), 64'(2'b01));
        step(1, 10'd2, 0, 0, 4'h0, 10'd4, 32'h0, g_i, g_d);
        chk("t2_ifgnt_next", 64'({g_i, g_d}), 64'(2'b10));

        // 3: ten cycles of back-to-back loads with a fetch always pending.
        for (int i = 0; i < 10; i++) begin
            step(1, 10'd3, 1, 0, 4'h0, ADDR_W'(5 + i), 32'h0, g_i, g_d);
            gseq[9 - i] = g_d;
        end
        chk("t3_pattern", 64'(gseq), 64'(10'b1111011110));

        // 4: store to byte 0x020 = word 8, then load it back-to-back.
        step(0, 10'd0, 1, 1, 4'hF, 10'd8, 32'h0BAD_F01D, g_i, g_d);
        step(0, 10'd0, 1, 0, 4'h0, 10'd8, 32'h0, g_i, g_d);
        chk("t4_store_done", 64'(bus_if.d_rvalid), 64'(1));
        step(0, 10'd0, 0, 0, 4'h0, 10'd0, 32'h0, g_i, g_d);
        chk("t4_load_data", 64'(bus_if.d_rdata), 64'h0BAD_F01D);

        // 5: single-byte store over 0x0BADF00D.
        step(0, 10'd0, 1, 1, 4'hF, 10'd9, 32'h0BAD_F00D, g_i, g_d);
        step(0, 10'd0, 1, 1, 4'h1, 10'd9, 32'hFFFF_FF1D, g_i, g_d);
        step(0, 10'd0, 1, 0, 4'h0, 10'd9, 32'h0, g_i, g_d);
        step(0, 10'd0, 0, 0, 4'h0, 10'd0, 32'h0, g_i, g_d);
        chk("t5_load_data", 64'(bus_if.d_rdata), 64'h0BAD_F01D);

        // 6: reset right after a grant drops the pending return.
        step(1, 10'd1, 0, 0, 4'h0, 10'd0, 32'h0, g_i, g_d);
        rst_n = 1'b0;
        #1;
        chk("t6_if_rvalid", 64'(bus_if.if_rvalid), 64'(0));
        chk("t6_if_rdata", 64'(bus_if.if_rdata), 64'(0));
        chk("t6_d_rdata", 64'(bus_if.d_rdata), 64'(0));
        bus_if.if_req = 1'b1; bus_if.d_req = 1'b1; bus_if.d_we = 1'b0;
        #1;
        chk("t6_rst_dgnt", 64'({bus_if.if_gnt, bus_if.d_gnt}), 64'(2'b01));
        @(posedge clk);
        #1;
        chk("t6_rst_rvalid", 64'({bus_if.if_rvalid, bus_if.d_rvalid}), 64'(0));
        bus_if.if_req = 1'b0; bus_if.d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("t6_post_rvalid", 64'({bus_if.if_rvalid, bus_if.d_rvalid}), 64'(0));
        @(negedge clk);
        step(0, 10'd0, 0, 0, 4'h0, 10'd0, 32'h0, g_i, g_d);

        // Random traffic: each request is held with stable fields until granted.
        r_ifr = 0; r_dr = 0;
        r_ifa = '0; r_da = '0; r_dwe = 0; r_dbe = '0; r_dwd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!r_ifr && ($urandom_range(3) != 0)) begin
                r_ifr = 1;
                r_ifa = ADDR_W'($urandom_range(NWORDS - 1));
            end
            if (!r_dr && ($urandom_range(3) != 0)) begin
                r_dr  = 1;
                r_dwe = 1'($urandom_range(1));
                r_dbe = 4'($urandom);
                r_da  = ADDR_W'($urandom_range(7));
                r_dwd = $urandom;
            end
            step(r_ifr, r_ifa, r_dr, r_dwe, r_dbe, r_da, r_dwd, g_i, g_d);
            if (g_i) r_ifr = 0;
            if (g_d) r_dr = 0;
        end
        step(0, 10'd0, 0, 0, 4'h0, 10'd0, 32'h0, g_i, g_d);
        step(0, 10'd0, 0, 0, 4'h0, 10'd0, 32'h0, g_i, g_d);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
